i2c_config_sequencer: RTL and testbench



---
 rtl/i2c_config_sequencer_if.sv | 22 ++
 rtl/i2c_config_sequencer.sv | 166 ++++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_config_sequencer_if.sv
// Command/handshake bundle between the codec config sequencer and the I2C master engine.
// "master" is the sequencer side (issues words), "slave" is the I2C engine side.
interface i2c_config_sequencer_if;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end;
  logic        i2c_ack;

  modport master (
    output i2c_data,
    output i2c_go,
    input  i2c_end,
    input  i2c_ack
  );

  modport slave (
    input  i2c_data,
    input  i2c_go,
    output i2c_end,
    output i2c_ack
  );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Power-up register-write sequencer for the WM8731 codec: walks a fixed table,
// hands one {addr, reg, val} word at a time to the I2C master, retries NACKs/timeouts.
module i2c_config_sequencer #(
  parameter logic [7:0]  DEV_ADDR      = 8'h34,
  parameter int          NUM_REGS      = 11,
  parameter logic [15:0] STARTUP_DELAY = 16'd50000,
  parameter logic [15:0] GAP_CYCLES    = 16'd1350,
  parameter logic [15:0] START_TIMEOUT = 16'd2700,
  parameter int          MAX_RETRIES   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          reconfig,
  i2c_config_sequencer_if.master        bus,
  output logic [3:0]                    cfg_index,
  output logic                          config_done,
  output logic                          config_error
);

  localparam logic [3:0] LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [3:0] MAX_RETRY = 4'(MAX_RETRIES);

  typedef enum logic [3:0] {
    S_PWR,
    S_LOAD,
    S_START,
    S_BUSY,
    S_CHECK,
    S_FAIL,
    S_GAP,
    S_DONE,
    S_HALT
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [3:0]  retry;
  logic        advance;

  // {reg[6:0], val[8:0]}; indices past the table never get loaded.
  function automatic logic [15:0] reg_entry(input logic [3:0] idx);
    logic [15:0] e;
    case (idx)
      4'd0:    e = {7'h0F, 9'h000};
      4'd1:    e = {7'h06, 9'h010};
      4'd2:    e = {7'h00, 9'h017};
      4'd3:    e = {7'h01, 9'h017};
      4'd4:    e = {7'h02, 9'h079};
      4'd5:    e = {7'h03, 9'h079};
      4'd6:    e = {7'h04, 9'h012};
      4'd7:    e = {7'h05, 9'h000};
      4'd8:    e = {7'h07, 9'h002};
      4'd9:    e = {7'h08, 9'h000};
      4'd10:   e = {7'h09, 9'h001};
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_PWR;
      cnt          <= 16'd0;
      retry        <= 4'd0;
      advance      <= 1'b0;
      cfg_index    <= 4'd0;
      config_done  <= 1'b0;
      config_error <= 1'b0;
      bus.i2c_go   <= 1'b0;
      bus.i2c_data <= 24'h0;
    end else if (reconfig) begin
      // Restart from entry 0 without the power-up wait; dropping go aborts the master.
      state        <= S_LOAD;
      cnt          <= 16'd0;
      retry        <= 4'd0;
      advance      <= 1'b0;
      cfg_index    <= 4'd0;
      config_done  <= 1'b0;
      config_error <= 1'b0;
      bus.i2c_go   <= 1'b0;
    end else begin
      case (state)
        S_PWR: begin
          if (cnt == STARTUP_DELAY - 16'd1) begin
            cnt   <= 16'd0;
            state <= S_LOAD;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_LOAD: begin
          // Data settles here; go is raised only from S_START so the word is stable first.
          bus.i2c_data <= {DEV_ADDR, reg_entry(cfg_index)};
          cnt          <= 16'd0;
          state        <= S_START;
        end
        S_START: begin
          bus.i2c_go <= 1'b1;
          if (!bus.i2c_end) begin
            cnt   <= 16'd0;
            state <= S_BUSY;
          end else if (cnt == START_TIMEOUT - 16'd1) begin
            cnt   <= 16'd0;
            state <= S_FAIL;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_BUSY: begin
          if (bus.i2c_end) state <= S_CHECK;
        end
        S_CHECK: begin
          if (!bus.i2c_ack) begin
            retry      <= 4'd0;
            advance    <= 1'b1;
            bus.i2c_go <= 1'b0;
            cnt        <= 16'd0;
            state      <= S_GAP;
          end else begin
            state <= S_FAIL;
          end
        end
        S_FAIL: begin
          if (retry < MAX_RETRY) begin
            retry      <= retry + 4'd1;
            advance    <= 1'b0;
            bus.i2c_go <= 1'b0;
            cnt        <= 16'd0;
            state      <= S_GAP;
          end else begin
            config_error <= 1'b1;
            bus.i2c_go   <= 1'b0;
            state        <= S_HALT;
          end
        end
        S_GAP: begin
          bus.i2c_go <= 1'b0;
          if (cnt == GAP_CYCLES - 16'd1) begin
            cnt <= 16'd0;
            if (advance && (cfg_index == LAST_IDX)) begin
              config_done <= 1'b1;
              state       <= S_DONE;
            end else begin
              if (advance) cfg_index <= cfg_index + 4'd1;
              state <= S_LOAD;
            end
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_DONE, S_HALT: begin
          bus.i2c_go <= 1'b0;
        end
        default: begin
          bus.i2c_go <= 1'b0;
          state      <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer with a behavioural I2C master model
// (shortened delays so the whole run stays small).
module tb_i2c_config_sequencer;
  localparam logic [15:0] SD  = 16'd200;
  localparam logic [15:0] GAP = 16'd20;
  localparam logic [15:0] TO  = 16'd40;

  logic       clk = 1'b0;
  logic       reset;
  logic       reconfig;
  logic [3:0] cfg_index;
  logic       config_done;
  logic       config_error;

  i2c_config_sequencer_if bus();

  i2c_config_sequencer #(
    .STARTUP_DELAY(SD),
    .GAP_CYCLES   (GAP),
    .START_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reconfig    (reconfig),
    .bus         (bus.master),
    .cfg_index   (cfg_index),
    .config_done (config_done),
    .config_error(config_error)
  );

  always #5 clk = ~clk;

  logic [23:0] exp_word [11] = '{24'h341E00, 24'h340C10, 24'h340017, 24'h340217,
                                 24'h340479, 24'h340679, 24'h340812, 24'h340A00,
                                 24'h340E02, 24'h341000, 24'h341201};

  int tests = 0;
  int fails = 0;

  // Master model state (owned by the model process)
  logic [23:0] log_word [128];
  logic [3:0]  log_idx  [128];
  int   tx_count    = 0;
  int   nacks_given = 0;
  int   hi_cnt = 0, lo_cnt = 0, hi_len = 0, gap_len = 0, m_cnt = 0;
  logic m_started = 1'b0, m_busy = 1'b0;
  // Model knobs (owned by the stimulus process)
  int          nack_limit = 0;
  int          m_len      = 5;
  logic [23:0] nack_word  = 24'h0;
  logic        stuck      = 1'b0;

  always @(negedge clk) begin
    if (bus.i2c_go) begin
      if (lo_cnt != 0) gap_len = lo_cnt;
      lo_cnt = 0;
      hi_cnt++;
    end else begin
      if (hi_cnt != 0) hi_len = hi_cnt;
      hi_cnt = 0;
      lo_cnt++;
    end
    if (!bus.i2c_go) begin
      bus.i2c_end = 1'b1;
      bus.i2c_ack = 1'b0;
      m_started   = 1'b0;
      m_busy      = 1'b0;
      m_cnt       = 0;
    end else if (!m_started) begin
      m_started = 1'b1;
      if (tx_count < 128) begin
        log_word[7'(tx_count)] = bus.i2c_data;
        log_idx[7'(tx_count)]  = cfg_index;
      end
      tx_count++;
      if (!stuck) begin
        m_busy      = 1'b1;
        m_cnt       = 0;
        bus.i2c_end = 1'b0;
      end
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt >= m_len) begin
        m_busy      = 1'b0;
        bus.i2c_end = 1'b1;
        if (bus.i2c_data == nack_word && nacks_given < nack_limit) begin
          bus.i2c_ack = 1'b1;
          nacks_given++;
        end else begin
          bus.i2c_ack = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reconfig();
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    reset    = 1'b0;
    reconfig = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_go",   32'(bus.i2c_go),   32'd0);
    chk("rst_data", 32'(bus.i2c_data), 32'h0);
    chk("rst_idx",  32'(cfg_index),    32'd0);
    chk("rst_done", 32'(config_done),  32'd0);
    chk("rst_err",  32'(config_error), 32'd0);

    // Full sequence after power-up, everything ACKed
    base  = tx_count;
    reset = 1'b1;
    n = 0;
    while (!bus.i2c_go && n < 1000) begin @(negedge clk); n++; end
    chk("startup_delay", 32'(n), 32'(SD) + 32'd2);
    chk("first_word", 32'(bus.i2c_data), 32'h341E00);
    n = 0;
    while (!config_done && n < 5000) begin @(negedge clk); n++; end
    chk("t1_done_reached", 32'(n < 5000), 32'd1);
    chk("t1_count", 32'(tx_count - base), 32'd11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("t1_word%0d", i), 32'(log_word[7'(base + i)]), 32'(exp_word[i]));
    chk("t1_err",  32'(config_error), 32'd0);
    chk("t1_go",   32'(bus.i2c_go),   32'd0);
    chk("t1_idx",  32'(cfg_index),    32'd10);
    chk("t1_gap",  32'(gap_len),      32'(GAP) + 32'd2);

    // Entry 4 NACKed once, resent, then sequence completes
    nack_word  = 24'h340479;
    nack_limit = nacks_given + 1;
    base = tx_count;
    pulse_reconfig();
    chk("t2_done_clr", 32'(config_done), 32'd0);
    n = 0;
    while (!bus.i2c_go && n < 100) begin @(negedge clk); n++; end
    chk("t2_no_delay", 32'(n), 32'd2);
    n = 0;
    while (!config_done && n < 5000) begin @(negedge clk); n++; end
    chk("t2_done_reached", 32'(n < 5000), 32'd1);
    chk("t2_count",  32'(tx_count - base), 32'd12);
    chk("t2_first",  32'(log_word[7'(base)]),     32'h341E00);
    chk("t2_try1",   32'(log_word[7'(base + 4)]), 32'h340479);
    chk("t2_try2",   32'(log_word[7'(base + 5)]), 32'h340479);
    chk("t2_idx_rt", 32'(log_idx[7'(base + 5)]),  32'd4);
    chk("t2_next",   32'(log_word[7'(base + 6)]), 32'h340679);
    chk("t2_last",   32'(log_word[7'(base + 11)]), 32'h341201);
    chk("t2_err",    32'(config_error), 32'd0);

    // Entry 2 always NACKed: three attempts then halt with error
    nack_word  = 24'h340017;
    nack_limit = nacks_given + 1000;
    base = tx_count;
    pulse_reconfig();
    n = 0;
    while (!config_error && n < 5000) begin @(negedge clk); n++; end
    chk("t3_err_reached", 32'(n < 5000), 32'd1);
    repeat (50) @(negedge clk);
    chk("t3_count", 32'(tx_count - base), 32'd5);
    chk("t3_a1", 32'(log_word[7'(base + 2)]), 32'h340017);
    chk("t3_a2", 32'(log_word[7'(base + 3)]), 32'h340017);
    chk("t3_a3", 32'(log_word[7'(base + 4)]), 32'h340017);
    chk("t3_err",  32'(config_error), 32'd1);
    chk("t3_done", 32'(config_done),  32'd0);
    chk("t3_idx",  32'(cfg_index),    32'd2);
    chk("t3_go",   32'(bus.i2c_go),   32'd0);
    nack_limit = nacks_given;

    // Master never leaves idle: start timeout, three failures, error
    stuck = 1'b1;
    base  = tx_count;
    pulse_reconfig();
    n = 0;
    while (!config_error && n < 5000) begin @(negedge clk); n++; end
    chk("t4_err_reached", 32'(n < 5000), 32'd1);
    repeat (10) @(negedge clk);
    chk("t4_count",  32'(tx_count - base), 32'd3);
    chk("t4_go_len", 32'(hi_len),       32'(TO));
    chk("t4_idx",    32'(cfg_index),    32'd0);
    chk("t4_done",   32'(config_done),  32'd0);
    chk("t4_go",     32'(bus.i2c_go),   32'd0);
    stuck = 1'b0;

    // reconfig in the middle of entry 6's transfer
    m_len = 30;
    base  = tx_count;
    pulse_reconfig();
    n = 0;
    while (tx_count < base + 7 && n < 5000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    chk("t5_busy_go",  32'(bus.i2c_go), 32'd1);
    chk("t5_busy_idx", 32'(cfg_index),  32'd6);
    pulse_reconfig();
    chk("t5_go_drop", 32'(bus.i2c_go), 32'd0);
    chk("t5_idx_clr", 32'(cfg_index),  32'd0);
    n = 0;
    while (!bus.i2c_go && n < 100) begin @(negedge clk); n++; end
    chk("t5_no_delay", 32'(n), 32'd2);
    @(negedge clk);
    chk("t5_restart_word", 32'(log_word[7'(base + 7)]), 32'h341E00);
    n = 0;
    while (!config_done && n < 5000) begin @(negedge clk); n++; end
    chk("t5_done_reached", 32'(n < 5000), 32'd1);
    chk("t5_count", 32'(tx_count - base), 32'd18);
    chk("t5_last",  32'(log_word[7'(base + 17)]), 32'h341201);

    // Asynchronous reset during a transfer
    base = tx_count;
    pulse_reconfig();
    n = 0;
    while (tx_count < base + 3 && n < 5000) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk("t6_busy_go", 32'(bus.i2c_go), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_go",   32'(bus.i2c_go),   32'd0);
    chk("t6_data", 32'(bus.i2c_data), 32'h0);
    chk("t6_idx",  32'(cfg_index),    32'd0);
    chk("t6_done", 32'(config_done),  32'd0);
    chk("t6_err",  32'(config_error), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (!bus.i2c_go && n < 1000) begin @(negedge clk); n++; end
    chk("t6_startup_delay", 32'(n), 32'(SD) + 32'd2);
    chk("t6_first_word", 32'(bus.i2c_data), 32'h341E00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
